// File: rtl/core_bp_pkg.sv
// Shared branch-prediction types: BTB entry type codes, RAS defaults, and the RAS op encoding.
package core_bp_pkg;

    localparam int RAS_DEPTH_DEF = 8;
    localparam int RAS_AW_DEF    = 32;

    localparam logic [1:0] none         = 2'd0;
    localparam logic [1:0] jal_btb_type = 2'd1;
    localparam logic [1:0] jr_btb_type  = 2'd2;
    localparam logic [1:0] br_btb_type  = 2'd3;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } ras_op_e;

endpackage

// File: rtl/core_ras_mem.sv
// RAS entry storage: DEPTH x AW register array with one write port,
// one asynchronous read port and a synchronous clear.
module core_ras_mem
    import core_bp_pkg::*;
#(
    parameter  int DEPTH = RAS_DEPTH_DEF,
    parameter  int AW    = RAS_AW_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [AW-1:0]    wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [AW-1:0]    rdata
);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/core_ras_ckpt.sv
// Return address stack with circular overflow, underflow flagging and ID-recovery priority.
// Optional pointer/count checkpointing is enabled by defining RAS_CKPT_EN.
module core_ras_ckpt
    import core_bp_pkg::*;
#(
    parameter  int DEPTH = RAS_DEPTH_DEF,
    parameter  int AW    = RAS_AW_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           en_call_in,
    input  logic           en_ret_in,
    input  logic [AW-1:0]  ret_addr_in,
    input  logic           recover_push,
    input  logic [AW-1:0]  recover_push_addr,
    input  logic           recover_pop,
    input  logic           ckpt_save,
    input  logic           ckpt_restore,
    output logic [AW-1:0]  ret_addr_out,
    output logic           ret_valid,
    output logic [PTR_W:0] count,
    output logic           overflow,
    output logic           underflow
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] tos_q, tos_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    ras_op_e          op;
    logic [AW-1:0]    op_addr;
    logic             restore;
    logic             we;
    logic [PTR_W-1:0] waddr;
    logic [AW-1:0]    rdata;

`ifdef RAS_CKPT_EN
    logic [PTR_W-1:0] shadow_tos_q, shadow_tos_d;
    logic [PTR_W:0]   shadow_count_q, shadow_count_d;

    assign restore = ckpt_restore;

    always_comb begin
        shadow_tos_d   = shadow_tos_q;
        shadow_count_d = shadow_count_q;
        if (ckpt_save && !ckpt_restore) begin
            shadow_tos_d   = tos_q;
            shadow_count_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_tos_q   <= '0;
            shadow_count_q <= '0;
        end else begin
            shadow_tos_q   <= shadow_tos_d;
            shadow_count_q <= shadow_count_d;
        end
    end
`else
    logic unused_ckpt;

    assign restore     = 1'b0;
    assign unused_ckpt = ckpt_save ^ ckpt_restore;
`endif

    // Recovery or restore flushes IF, so IF ops only win when both are idle.
    always_comb begin
        op      = OP_NONE;
        op_addr = ret_addr_in;
        if (restore) begin
            op = OP_NONE;
        end else if (recover_push || recover_pop) begin
            if (recover_push && !recover_pop) begin
                op      = OP_PUSH;
                op_addr = recover_push_addr;
            end else if (recover_pop && !recover_push) begin
                op = OP_POP;
            end
        end else if (!stall) begin
            if (en_call_in && en_ret_in) begin
                op = OP_REPL;
            end else if (en_call_in) begin
                op = OP_PUSH;
            end else if (en_ret_in) begin
                op = OP_POP;
            end
        end
    end

    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        we          = 1'b0;
        waddr       = tos_q;
        case (op)
            OP_PUSH: begin
                tos_d = tos_q + 1'b1;
                waddr = tos_d;
                we    = 1'b1;
                if (count_q == FULL_CNT) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            OP_POP: begin
                if (count_q != '0) begin
                    tos_d   = tos_q - 1'b1;
                    count_d = count_q - 1'b1;
                end else begin
                    underflow_d = 1'b1;
                end
            end
            // Replacing the top of an empty stack degenerates to a push.
            OP_REPL: begin
                we = 1'b1;
                if (count_q == '0) begin
                    tos_d   = tos_q + 1'b1;
                    waddr   = tos_d;
                    count_d = (PTR_W+1)'(1);
                end
            end
            default: ;
        endcase
`ifdef RAS_CKPT_EN
        if (ckpt_restore) begin
            tos_d   = shadow_tos_q;
            count_d = shadow_count_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            tos_q       <= tos_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    core_ras_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (op_addr),
        .raddr (tos_q),
        .rdata (rdata)
    );

    assign ret_addr_out = (count_q != '0) ? rdata : '0;
    assign ret_valid    = (count_q != '0);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_core_ras_ckpt.sv
// Directed self-checking bench for core_ras_ckpt (DEPTH=8, AW=32); checkpoint steps run when RAS_CKPT_EN is defined.
module tb_core_ras_ckpt;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        en_call_in;
    logic        en_ret_in;
    logic [31:0] ret_addr_in;
    logic        recover_push;
    logic [31:0] recover_push_addr;
    logic        recover_pop;
    logic        ckpt_save;
    logic        ckpt_restore;
    logic [31:0] ret_addr_out;
    logic        ret_valid;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int vectors;
    int miscompares;

    core_ras_ckpt dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .en_call_in        (en_call_in),
        .en_ret_in         (en_ret_in),
        .ret_addr_in       (ret_addr_in),
        .recover_push      (recover_push),
        .recover_push_addr (recover_push_addr),
        .recover_pop       (recover_pop),
        .ckpt_save         (ckpt_save),
        .ckpt_restore      (ckpt_restore),
        .ret_addr_out      (ret_addr_out),
        .ret_valid         (ret_valid),
        .count             (count),
        .overflow          (overflow),
        .underflow         (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock the currently driven inputs in, then return all op strobes to idle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        stall        = 1'b0;
        en_call_in   = 1'b0;
        en_ret_in    = 1'b0;
        recover_push = 1'b0;
        recover_pop  = 1'b0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp_addr,
                               input logic exp_valid, input logic [3:0] exp_count,
                               input logic exp_ovf, input logic exp_unf);
        vectors++;
        assert (ret_addr_out === exp_addr) else begin
            miscompares++;
            $error("[TB] FAIL %s.addr observed=%0h expected=%0h", tag, ret_addr_out, exp_addr);
        end
        vectors++;
        assert (ret_valid === exp_valid) else begin
            miscompares++;
            $error("[TB] FAIL %s.valid observed=%0b expected=%0b", tag, ret_valid, exp_valid);
        end
        vectors++;
        assert (count === exp_count) else begin
            miscompares++;
            $error("[TB] FAIL %s.count observed=%0d expected=%0d", tag, count, exp_count);
        end
        vectors++;
        assert (overflow === exp_ovf) else begin
            miscompares++;
            $error("[TB] FAIL %s.overflow observed=%0b expected=%0b", tag, overflow, exp_ovf);
        end
        vectors++;
        assert (underflow === exp_unf) else begin
            miscompares++;
            $error("[TB] FAIL %s.underflow observed=%0b expected=%0b", tag, underflow, exp_unf);
        end
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst               = 1'b1;
        stall             = 1'b0;
        en_call_in        = 1'b0;
        en_ret_in         = 1'b0;
        ret_addr_in       = '0;
        recover_push      = 1'b0;
        recover_push_addr = '0;
        recover_pop       = 1'b0;
        ckpt_save         = 1'b0;
        ckpt_restore      = 1'b0;

        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        checkOutput("reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Basic LIFO order.
        en_call_in = 1'b1; ret_addr_in = 32'h100; applyStimulus();
        checkOutput("push1", 32'h100, 1'b1, 4'd1, 1'b0, 1'b0);
        en_call_in = 1'b1; ret_addr_in = 32'h200; applyStimulus();
        checkOutput("push2", 32'h200, 1'b1, 4'd2, 1'b0, 1'b0);
        en_call_in = 1'b1; ret_addr_in = 32'h300; applyStimulus();
        checkOutput("push3", 32'h300, 1'b1, 4'd3, 1'b0, 1'b0);
        en_ret_in = 1'b1; applyStimulus();
        checkOutput("pop1", 32'h200, 1'b1, 4'd2, 1'b0, 1'b0);
        en_ret_in = 1'b1; applyStimulus();
        checkOutput("pop2", 32'h100, 1'b1, 4'd1, 1'b0, 1'b0);
        en_ret_in = 1'b1; applyStimulus();
        checkOutput("pop3", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Nine pushes into eight entries: the ninth wraps and flags overflow.
        for (int i = 1; i <= 9; i++) begin
            en_call_in = 1'b1; ret_addr_in = 32'(i * 16); applyStimulus();
            checkOutput($sformatf("wrap_push%0d", i), 32'(i * 16), 1'b1,
                        4'((i > 8) ? 8 : i), 1'b0 | (i == 9), 1'b0);
        end
        for (int k = 1; k <= 8; k++) begin
            en_ret_in = 1'b1; applyStimulus();
            checkOutput($sformatf("wrap_pop%0d", k), (k == 8) ? 32'h0 : 32'((9 - k) * 16),
                        k != 8, 4'(8 - k), 1'b0, 1'b0);
        end
        en_ret_in = 1'b1; applyStimulus();
        checkOutput("underflow", 32'h0, 1'b0, 4'd0, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("underflow_clear", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Recovery pop suppresses a same-cycle IF push.
        en_call_in = 1'b1; ret_addr_in = 32'h11; applyStimulus();
        en_call_in = 1'b1; ret_addr_in = 32'h22; applyStimulus();
        checkOutput("pre_recpop", 32'h22, 1'b1, 4'd2, 1'b0, 1'b0);
        en_call_in = 1'b1; ret_addr_in = 32'h44; recover_pop = 1'b1; applyStimulus();
        checkOutput("recpop_vs_call", 32'h11, 1'b1, 4'd1, 1'b0, 1'b0);

        // Wrong JR prediction repaired by a recovery push.
        en_call_in = 1'b1; ret_addr_in = 32'hA0; applyStimulus();
        checkOutput("push_a0", 32'hA0, 1'b1, 4'd2, 1'b0, 1'b0);
        en_ret_in = 1'b1; applyStimulus();
        checkOutput("spec_pop_a0", 32'h11, 1'b1, 4'd1, 1'b0, 1'b0);
        recover_push = 1'b1; recover_push_addr = 32'hA0; applyStimulus();
        checkOutput("recpush_a0", 32'hA0, 1'b1, 4'd2, 1'b0, 1'b0);

        // Stall blocks IF; call+ret replaces the top; push+pop recovery is a no-op.
        stall = 1'b1; en_call_in = 1'b1; ret_addr_in = 32'h55; applyStimulus();
        checkOutput("stall_call", 32'hA0, 1'b1, 4'd2, 1'b0, 1'b0);
        en_call_in = 1'b1; en_ret_in = 1'b1; ret_addr_in = 32'h66; applyStimulus();
        checkOutput("replace_top", 32'h66, 1'b1, 4'd2, 1'b0, 1'b0);
        recover_push = 1'b1; recover_pop = 1'b1; recover_push_addr = 32'h99; applyStimulus();
        checkOutput("rec_both_noop", 32'h66, 1'b1, 4'd2, 1'b0, 1'b0);
        stall = 1'b1; recover_pop = 1'b1; applyStimulus();
        checkOutput("recpop_in_stall", 32'h11, 1'b1, 4'd1, 1'b0, 1'b0);
        en_ret_in = 1'b1; applyStimulus();
        checkOutput("drain", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        en_call_in = 1'b1; en_ret_in = 1'b1; ret_addr_in = 32'h77; applyStimulus();
        checkOutput("replace_empty", 32'h77, 1'b1, 4'd1, 1'b0, 1'b0);
        en_ret_in = 1'b1; applyStimulus();
        checkOutput("drain2", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);

`ifdef RAS_CKPT_EN
        en_call_in = 1'b1; ret_addr_in = 32'h1; applyStimulus();
        ckpt_save = 1'b1; applyStimulus();
        en_call_in = 1'b1; ret_addr_in = 32'h2; applyStimulus();
        en_call_in = 1'b1; ret_addr_in = 32'h3; applyStimulus();
        checkOutput("ckpt_pre", 32'h3, 1'b1, 4'd3, 1'b0, 1'b0);
        ckpt_restore = 1'b1; recover_pop = 1'b1; en_call_in = 1'b1; applyStimulus();
        checkOutput("ckpt_restore", 32'h1, 1'b1, 4'd1, 1'b0, 1'b0);
        en_call_in = 1'b1; ret_addr_in = 32'h4; applyStimulus();
        ckpt_save = 1'b1; ckpt_restore = 1'b1; applyStimulus();
        checkOutput("save_restore_same", 32'h1, 1'b1, 4'd1, 1'b0, 1'b0);
        en_ret_in = 1'b1; applyStimulus();
        checkOutput("ckpt_drain", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
`endif

        // Reset in the middle of activity wins over a same-cycle push.
        en_call_in = 1'b1; ret_addr_in = 32'h5; applyStimulus();
        en_call_in = 1'b1; ret_addr_in = 32'h6; applyStimulus();
        checkOutput("pre_midrst", 32'h6, 1'b1, 4'd2, 1'b0, 1'b0);
        rst = 1'b1; en_call_in = 1'b1; ret_addr_in = 32'h7; applyStimulus();
        rst = 1'b0;
        checkOutput("mid_reset", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        en_ret_in = 1'b1; applyStimulus();
        checkOutput("post_rst_unf", 32'h0, 1'b0, 4'd0, 1'b0, 1'b1);
        en_call_in = 1'b1; ret_addr_in = 32'h8; applyStimulus();
        checkOutput("post_rst_push", 32'h8, 1'b1, 4'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
